// File: rtl/dpcm_pkg.sv
// ---------------------------------------------------------------------------
// dpcm_pkg
// Purpose : Shared constants and types for the DPCM decoder slice.
// Contents: DATA_W_DEFAULT  - default reconstructed sample width in bits
//           sample_t        - unsigned reconstructed sample (default width)
//           diff_t          - signed difference, one bit wider than a sample
//           state_t         - output stage state {EMPTY, FULL}
// ---------------------------------------------------------------------------
package dpcm_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef logic        [DATA_W_DEFAULT-1:0] sample_t;
    typedef logic signed [DATA_W_DEFAULT:0]   diff_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/dpcm_decoder_if.sv
// ---------------------------------------------------------------------------
// dpcm_decoder_if
// Purpose : Groups the input (difference) and output (sample) handshakes of
//           the DPCM decoder into one bundle.
// Signals : Valid/Ready/DataIn             - difference stream into decoder
//           OutValid/OutReady/DataOut      - reconstructed sample stream out
//           FrameStart                     - first sample of a frame, with
//                                            OutValid
// Modports: slave  - decoder side
//           master - environment side (drives differences, consumes samples)
// ---------------------------------------------------------------------------
interface dpcm_decoder_if
    import dpcm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic              Valid;
    logic              Ready;
    logic [DATA_W:0]   DataIn;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] DataOut;
    logic              FrameStart;

    modport slave (
        input  Valid,
        input  DataIn,
        input  OutReady,
        output Ready,
        output OutValid,
        output DataOut,
        output FrameStart
    );

    modport master (
        output Valid,
        output DataIn,
        output OutReady,
        input  Ready,
        input  OutValid,
        input  DataOut,
        input  FrameStart
    );

endinterface

// File: rtl/dpcm_recon.sv
// ---------------------------------------------------------------------------
// dpcm_recon
// Purpose : Combinational add-and-limit: predictor + difference, reduced to
//           a DATA_W-bit unsigned sample.
// Ports   : pred   - predictor (unsigned, DATA_W bits)
//           diff   - two's-complement difference (DATA_W+1 bits)
//           result - reconstructed sample (DATA_W bits)
// Config  : DPCM_DEC_SAT_EN defined   -> clamp to [0, 2**DATA_W-1]
//           DPCM_DEC_SAT_EN undefined -> wrap modulo 2**DATA_W
// ---------------------------------------------------------------------------
module dpcm_recon
    import dpcm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic        [DATA_W-1:0] pred,
    input  logic signed [DATA_W:0]   diff,
    output logic        [DATA_W-1:0] result
);

    // Sum spans -2**DATA_W .. 2*(2**DATA_W)-2, so DATA_W+2 signed bits is exact.
    logic signed [DATA_W+1:0] sum;

    always_comb begin
        sum = $signed({2'b00, pred}) + (DATA_W+2)'(diff);
`ifdef DPCM_DEC_SAT_EN
        // Top bit set means negative; next bit set means above full scale.
        if (sum[DATA_W+1]) begin
            result = '0;
        end else if (sum[DATA_W]) begin
            result = '1;
        end else begin
            result = DATA_W'(sum);
        end
`else
        result = DATA_W'(sum);
`endif
    end

endmodule

// File: rtl/dpcm_decoder.sv
// ---------------------------------------------------------------------------
// dpcm_decoder
// Purpose : DPCM decoder with a one-entry output register. Each accepted
//           difference is added to the predictor (the previous reconstructed
//           sample of the frame, or 0 on the first sample of a frame) and the
//           result appears on DataOut one cycle later.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - dpcm_decoder_if.slave (Valid/Ready/DataIn in,
//                  OutValid/OutReady/DataOut/FrameStart out)
// Params  : DATA_W    - sample width
//           FRAME_LEN - samples per frame (2..65535)
// Config  : DPCM_DEC_SAT_EN selects clamping instead of wrapping in
//           dpcm_recon.
// ---------------------------------------------------------------------------
module dpcm_decoder
    import dpcm_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int FRAME_LEN = 64
) (
    input  logic          clk,
    input  logic          rst,
    dpcm_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pred_q, pred_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              frame_start_q, frame_start_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ready;
    logic              out_valid;
    logic              in_xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] pred_used;
    logic [DATA_W-1:0] recon_result;

    // Output register can take a new sample when empty, or when the held
    // sample leaves in the same cycle.
    always_comb begin
        out_valid = (state_q == FULL);
        ready     = (state_q == EMPTY) || bus.OutReady;
    end

    assign in_xfer  = bus.Valid && ready;
    assign out_xfer = out_valid && bus.OutReady;

    assign bus.Ready      = ready;
    assign bus.OutValid   = out_valid;
    assign bus.DataOut    = data_q;
    assign bus.FrameStart = frame_start_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer) state_d = FULL;
            FULL:    if (out_xfer && !in_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A frame restarts with a zero predictor at counter value 0.
    always_comb begin
        pred_used = (count_q == '0) ? '0 : pred_q;
    end

    dpcm_recon #(
        .DATA_W (DATA_W)
    ) u_recon (
        .pred   (pred_used),
        .diff   (bus.DataIn),
        .result (recon_result)
    );

    // Predictor, counter and output only move on an input transfer, which
    // also keeps them frozen while the output is stalled.
    always_comb begin
        pred_d        = pred_q;
        data_d        = data_q;
        frame_start_d = frame_start_q;
        count_d       = count_q;
        if (in_xfer) begin
            pred_d        = recon_result;
            data_d        = recon_result;
            frame_start_d = (count_q == '0);
            if (count_q == CNT_W'(FRAME_LEN - 1)) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q        <= '0;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            count_q       <= '0;
        end else begin
            pred_q        <= pred_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            count_q       <= count_d;
        end
    end

endmodule

// File: tb/tb_dpcm_decoder.sv
// ---------------------------------------------------------------------------
// tb_dpcm_decoder
// Two decoders (frame lengths 5 and 4) share clock, reset and stimulus.
// A transaction-level model turns every accepted difference into the pair of
// expected samples and queues them; a negedge monitor compares handshake and
// data outputs of both decoders against that queue on every cycle. Directed
// sequences with literal expectations pin the model, then randomized traffic
// with occasional resets runs against it. Honors DPCM_DEC_SAT_EN.
// ---------------------------------------------------------------------------
module tb_dpcm_decoder;

    localparam int DW   = 8;
    localparam int MAXV = (1 << DW) - 1;
    localparam int FL0  = 5;
    localparam int FL1  = 4;

    logic clk;
    logic rst;

    dpcm_decoder_if #(.DATA_W(DW)) bus0 ();
    dpcm_decoder_if #(.DATA_W(DW)) bus1 ();

    dpcm_decoder #(.DATA_W(DW), .FRAME_LEN(FL0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dpcm_decoder #(.DATA_W(DW), .FRAME_LEN(FL1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        int d0;
        bit f0;
        int d1;
        bit f1;
    } exp_t;

    exp_t expQ[$];
    int   pred[2];
    int   cnt[2];
    int   flen[2] = '{FL0, FL1};

    int log0[$];
    bit logFs0[$];
    int log1[$];
    bit logFs1[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer sum, then clamp or wrap.
    function automatic int reconModel(input int p, input int d);
        int s;
        s = p + d;
`ifdef DPCM_DEC_SAT_EN
        if (s < 0) return 0;
        if (s > MAXV) return MAXV;
        return s;
`else
        return s & MAXV;
`endif
    endfunction

    function automatic void clearLogs();
        log0.delete();
        logFs0.delete();
        log1.delete();
        logFs1.delete();
    endfunction

    // Per-cycle compare against the expected-sample queue.
    always @(negedge clk) begin
        bit   inX, outX, modelFull;
        int   diff;
        exp_t e;
        if (rst) begin
            expQ.delete();
            pred = '{0, 0};
            cnt  = '{0, 0};
        end else begin
            modelFull = (expQ.size() != 0);
            checkOutput("ready0", bus0.Ready, (!modelFull || bus0.OutReady));
            checkOutput("ready1", bus1.Ready, (!modelFull || bus1.OutReady));
            checkOutput("outvalid0", bus0.OutValid, modelFull);
            checkOutput("outvalid1", bus1.OutValid, modelFull);
            if (modelFull) begin
                checkOutput("dataout0", {24'b0, bus0.DataOut}, expQ[0].d0);
                checkOutput("framestart0", bus0.FrameStart, expQ[0].f0);
                checkOutput("dataout1", {24'b0, bus1.DataOut}, expQ[0].d1);
                checkOutput("framestart1", bus1.FrameStart, expQ[0].f1);
            end
            inX  = bus0.Valid && (!modelFull || bus0.OutReady);
            outX = modelFull && bus0.OutReady;
            if (outX) begin
                log0.push_back(int'(bus0.DataOut));
                logFs0.push_back(bus0.FrameStart);
                log1.push_back(int'(bus1.DataOut));
                logFs1.push_back(bus1.FrameStart);
                void'(expQ.pop_front());
            end
            if (inX) begin
                diff = $signed(bus0.DataIn);
                for (int l = 0; l < 2; l++) begin
                    int p, r;
                    p = (cnt[l] == 0) ? 0 : pred[l];
                    r = reconModel(p, diff);
                    if (l == 0) begin
                        e.d0 = r;
                        e.f0 = (cnt[l] == 0);
                    end else begin
                        e.d1 = r;
                        e.f1 = (cnt[l] == 0);
                    end
                    pred[l] = r;
                    cnt[l]  = (cnt[l] + 1) % flen[l];
                end
                expQ.push_back(e);
            end
        end
    end

    // One cycle: drive at posedge+1, sample Ready at negedge, return at next posedge+1.
    task automatic applyStimulus(input bit v, input int d, input bit ordy, output bit rdy);
        logic [DW:0] tmp;
        tmp = d[DW:0];
        bus0.Valid    = v;
        bus1.Valid    = v;
        bus0.DataIn   = tmp;
        bus1.DataIn   = tmp;
        bus0.OutReady = ordy;
        bus1.OutReady = ordy;
        @(negedge clk);
        rdy = bus0.Ready;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus0.Valid    = 1'b0;
        bus1.Valid    = 1'b0;
        bus0.OutReady = 1'b1;
        bus1.OutReady = 1'b1;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", bus0.Ready, 1'b1);
        checkOutput("rst_outvalid", bus0.OutValid, 1'b0);
        checkOutput("rst_dataout", {24'b0, bus0.DataOut}, 0);
        checkOutput("rst_framestart", bus0.FrameStart, 1'b0);
        checkOutput("rst_outvalid1", bus1.OutValid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic sendSeq(input int seq[$]);
        bit rdy;
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b1, rdy);
        applyStimulus(1'b0, 0, 1'b1, rdy);
    endtask

    function automatic int randDiff();
        case ($urandom_range(0, 7))
            0:       return -(1 << DW);
            1:       return MAXV;
            2:       return int'($urandom_range(0, 6)) - 3;
            default: return int'($urandom_range(0, 2 * MAXV + 1)) - (1 << DW);
        endcase
    endfunction

    initial begin
        int  e33[5]  = '{10, 15, 12, 112, 0};
        bit  f33[5]  = '{1, 0, 0, 0, 0};
        int  e35[9]  = '{1, 2, 3, 4, 1, 2, 3, 4, 1};
        bit  f35[9]  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int  seq[$];
        bit  rdy;
        bit  pend;
        bit  v;
        int  pd;
        int  expHi, expLo;

        rst           = 1'b1;
        bus0.Valid    = 1'b0;
        bus1.Valid    = 1'b0;
        bus0.DataIn   = '0;
        bus1.DataIn   = '0;
        bus0.OutReady = 1'b1;
        bus1.OutReady = 1'b1;

        $display("[TB] start");
        doReset();

        // Basic frame of five on the FRAME_LEN=5 decoder.
        clearLogs();
        seq = '{10, 5, -3, 100, -112};
        sendSeq(seq);
        checkOutput("frame5_count", log0.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("frame5_data", (i < log0.size()) ? log0[i] : -1, e33[i]);
            checkOutput("frame5_fs", (i < logFs0.size()) ? logFs0[i] : 1'b0, f33[i]);
        end

        // Frame wrap on the FRAME_LEN=4 decoder.
        doReset();
        clearLogs();
        seq = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        sendSeq(seq);
        checkOutput("frame4_count", log1.size(), 9);
        for (int i = 0; i < 9; i++) begin
            checkOutput("frame4_data", (i < log1.size()) ? log1[i] : -1, e35[i]);
            checkOutput("frame4_fs", (i < logFs1.size()) ? logFs1[i] : 1'b0, f35[i]);
        end

        // Limit behaviour above full scale and below zero.
`ifdef DPCM_DEC_SAT_EN
        expHi = 255;
        expLo = 0;
`else
        expHi = 4;
        expLo = 254;
`endif
        doReset();
        clearLogs();
        seq = '{250, 10};
        sendSeq(seq);
        checkOutput("limit_high", (log0.size() == 2) ? log0[1] : -1, expHi);
        doReset();
        clearLogs();
        seq = '{3, -5};
        sendSeq(seq);
        checkOutput("limit_low", (log0.size() == 2) ? log0[1] : -1, expLo);

        // Output stall: Ready drops, nothing lost or duplicated.
        doReset();
        clearLogs();
        applyStimulus(1'b1, 20, 1'b1, rdy);
        repeat (3) begin
            applyStimulus(1'b1, 1, 1'b0, rdy);
            checkOutput("stall_ready", rdy, 1'b0);
        end
        applyStimulus(1'b1, 1, 1'b1, rdy);
        applyStimulus(1'b0, 0, 1'b1, rdy);
        checkOutput("stall_count", log0.size(), 2);
        checkOutput("stall_first", (log0.size() > 0) ? log0[0] : -1, 20);
        checkOutput("stall_second", (log0.size() > 1) ? log0[1] : -1, 21);

        // Continuous streaming: one sample per cycle.
        doReset();
        clearLogs();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, randDiff(), 1'b1, rdy);
            checkOutput("stream_ready", rdy, 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b1, rdy);
        checkOutput("stream_count", log0.size(), 20);

        // Reset while holding a sample mid-frame.
        doReset();
        seq = '{30, 4, 2};
        foreach (seq[i]) applyStimulus(1'b1, seq[i], 1'b1, rdy);
        applyStimulus(1'b1, 9, 1'b0, rdy);
        rst        = 1'b1;
        bus0.Valid = 1'b0;
        bus1.Valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_outvalid", bus0.OutValid, 1'b0);
        @(posedge clk);
        #1;
        clearLogs();
        applyStimulus(1'b1, 7, 1'b1, rdy);
        applyStimulus(1'b0, 0, 1'b1, rdy);
        checkOutput("midrst_data", (log0.size() == 1) ? log0[0] : -1, 7);
        checkOutput("midrst_fs", (logFs0.size() == 1) ? logFs0[0] : 1'b0, 1'b1);
        checkOutput("midrst_fs1", (logFs1.size() == 1) ? logFs1[0] : 1'b0, 1'b1);

        // Randomized traffic with back-pressure and occasional resets.
        pend = 1'b0;
        pd   = 0;
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom_range(0, 9) < 7) || pend;
            if (!pend) pd = randDiff();
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(v, pd, ($urandom_range(0, 9) < 7), rdy);
            pend = v && !(rdy && !rst);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 0, 1'b1, rdy);
        applyStimulus(1'b0, 0, 1'b1, rdy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
